manager_tx_frame: RTL
=====================

Name: manager_tx_frame

Overview:
- Parametrised transmit manager between the scoreboard control logic and the RS232 transmitter.
- Accepts {address, multi-byte data} requests into a small request FIFO.
- Serialises each request as a byte frame (address, data bytes MSB-first, optional XOR checksum).
- Paces bytes with a trigger/done handshake, with a done-timeout guard and sticky error flags.

Parameters:
DATA_BYTES, 2, data bytes per frame (1..4); data_tx width = 8*DATA_BYTES
FIFO_DEPTH, 4, request FIFO entries (power of two, 2..16)
CHECKSUM_EN, 1, 1 = append XOR checksum byte; 0 = no checksum
TIMEOUT_CYCLES, 65535, clocks to wait for RS_DONE per byte before aborting the frame (1..65535)

Ports:
CLK_50MHZ  in  1  system clock; single clock domain
RST  in  1  reset, asynchronous, active-high
tx_trig  in  1  push request; one cycle per request
addr_tx  in  8  address byte of request
data_tx  in  8*DATA_BYTES  data of request; byte DATA_BYTES-1 (MSB) sent first
tx_ready  out  1  high when FIFO not full
RS_DATAIN  out  8  byte presented to the transmitter
RS_TRG_WRITE  out  1  one-cycle write strobe to the transmitter
RS_DONE  in  1  one-cycle pulse from the transmitter: byte finished
busy  out  1  high while a frame is in progress (state != IDLE)
overflow  out  1  sticky: a request was dropped because the FIFO was full
timeout_err  out  1  sticky: a frame was aborted on timeout

Behaviour:
- Reset (async, immediate): RS_DATAIN=0, RS_TRG_WRITE=0, busy=0, overflow=0, timeout_err=0; FIFO emptied (count=0, so tx_ready=1); state=IDLE.
- All outputs are registered except tx_ready, which is decoded from the FIFO count.
- Sticky flags clear only on RST.
- FIFO push: on edge with tx_trig=1 and count<FIFO_DEPTH, store {addr_tx, data_tx}.
- FIFO full: tx_trig with count==FIFO_DEPTH drops the request and sets overflow. Fullness uses the pre-edge count; a pop on the same edge does not rescue the push.
- Simultaneous push and pop with count not full: count unchanged.
- Frame layout, length L = 1 + DATA_BYTES + CHECKSUM_EN:
  - addr
  - data[8*DATA_BYTES-1 -: 8] down to data[7:0]
  - checksum = XOR of all preceding bytes of the frame
- FSM states: IDLE, LOAD, SEND, WAIT_DONE.
  - IDLE: if count>0, pop head into frame register, byte index=0, checksum accumulator=0, go LOAD.
  - LOAD/SEND: RS_DATAIN<=current byte, RS_TRG_WRITE<=1 for exactly one cycle; accumulate XOR; clear timeout counter; go WAIT_DONE.
  - WAIT_DONE:
    - RS_DONE=1 and index==L-1: go IDLE.
    - RS_DONE=1 otherwise: index++, go SEND.
    - Timeout counter reaches TIMEOUT_CYCLES without RS_DONE: set timeout_err, discard rest of frame, go IDLE.
  - RS_DONE is ignored in the cycle RS_TRG_WRITE is high and in any state other than WAIT_DONE.
- Latency, FIFO empty and IDLE, tx_trig sampled on edge E:
  - E: push.
  - E+1: pop, state LOAD.
  - E+2: RS_TRG_WRITE rises with RS_DATAIN=addr.
  - E+3: RS_TRG_WRITE falls.
- Inter-byte gap: RS_DONE sampled on edge D gives next strobe high at D+1 (SEND executes on D+1).
- After a frame, IDLE costs one cycle before the next pop; back-to-back frames are separated by exactly one idle cycle.
- RS_DATAIN holds the last byte sent until the next strobe.
- busy rises on the pop edge and falls on the edge entering IDLE.
- Reset mid-frame: frame and queued requests lost; no further strobes.

Test Plan:
- Latency/frame: DATA_BYTES=2, CHECKSUM_EN=1. tx_trig at edge E with addr 0x12, data 0x3456; RS_DONE pulsed 10 cycles after each strobe.
  -> strobes carry 0x12, 0x34, 0x56, 0x70 in order; first strobe at E+2; busy low after the 4th RS_DONE.
- CHECKSUM_EN=0, DATA_BYTES=1. addr 0xA5, data 0xFF.
  -> exactly two strobes, 0xA5 then 0xFF; no third byte.
- Overflow: FIFO_DEPTH=4, RS_DONE held low, 6 tx_trig on consecutive edges.
  -> requests 1-5 accepted (request 1 popped at E+1); request 6 dropped; overflow=1, tx_ready=0.
  -> then release RS_DONE: frames 1-5 transmitted in order.
- Timeout: TIMEOUT_CYCLES=100, RS_DONE never asserted.
  -> single strobe; timeout_err=1 and busy=0 about 100 cycles later; a queued second request then starts normally.
- Spurious done: RS_DONE asserted in the same cycle as RS_TRG_WRITE.
  -> ignored; next byte waits for a later RS_DONE.
- Reset mid-frame: RST asserted between byte 2 and 3, with 2 requests queued.
  -> outputs 0 immediately (before next clock edge); after release, no strobes without new tx_trig; tx_ready=1.

Source files
------------

// File: rtl/manager_tx_frame.sv
// manager_tx_frame: queues {addr,data} requests and sends each one as a paced byte frame to an RS232 transmitter
module manager_tx_frame #(
  parameter int DATA_BYTES     = 2,
  parameter int FIFO_DEPTH     = 4,
  parameter int CHECKSUM_EN    = 1,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                    CLK_50MHZ,
  input  logic                    RST,
  input  logic                    tx_trig,
  input  logic [7:0]              addr_tx,
  input  logic [8*DATA_BYTES-1:0] data_tx,
  output logic                    tx_ready,
  output logic [7:0]              RS_DATAIN,
  output logic                    RS_TRG_WRITE,
  input  logic                    RS_DONE,
  output logic                    busy,
  output logic                    overflow,
  output logic                    timeout_err
);
  localparam int W = 8 + 8*DATA_BYTES;
  localparam int L = 1 + DATA_BYTES + CHECKSUM_EN;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);
  localparam logic [2:0] LAST = 3'(L-1);
  localparam logic [2:0] NDB = 3'(DATA_BYTES);
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES-1);
  typedef enum logic [1:0] {IDLE, LOAD, SEND, WAIT_DONE} state_t;
  state_t r_state, w_state_nx;
  logic [W-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0] r_cnt;
  logic [W-1:0] r_frame;
  logic [2:0] r_idx;
  logic [7:0] r_csum;
  logic [15:0] r_tmo;
  logic w_push, w_pop, w_send, w_done, w_tmo;
  logic [7:0] w_byte;
  assign tx_ready = r_cnt != FULL;
  // Handshake decode and next state; RS_DONE counts only in WAIT_DONE once the strobe has dropped
  always_comb begin
    w_push = tx_trig && r_cnt != FULL;
    w_pop = r_state == IDLE && r_cnt != '0;
    w_send = r_state == LOAD || r_state == SEND;
    w_done = r_state == WAIT_DONE && RS_DONE && !RS_TRG_WRITE;
    w_tmo = r_state == WAIT_DONE && !w_done && r_tmo == TMO_LAST;
    w_byte = r_idx > NDB ? r_csum : r_frame[W-1 -: 8];
    w_state_nx = w_pop ? LOAD :
                 w_send ? WAIT_DONE :
                 (w_tmo || (w_done && r_idx == LAST)) ? IDLE :
                 w_done ? SEND : r_state;
  end
  // FSM state register
  always_ff @(posedge CLK_50MHZ or posedge RST)
    if (RST) r_state <= IDLE;
    else r_state <= w_state_nx;
  // Request storage; contents need no reset since the count gates every read
  always_ff @(posedge CLK_50MHZ)
    if (w_push) r_mem[r_wp] <= {addr_tx, data_tx};
  // FIFO pointers, occupancy and the sticky drop flag
  always_ff @(posedge CLK_50MHZ or posedge RST)
    if (RST) begin
      r_wp <= '0;
      r_rp <= '0;
      r_cnt <= '0;
      overflow <= 1'b0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop) r_rp <= r_rp + 1'b1;
      r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
      if (tx_trig && !w_push) overflow <= 1'b1;
    end
  // Frame datapath: the frame shifts left so the next byte is always at the top, checksum follows the data
  always_ff @(posedge CLK_50MHZ or posedge RST)
    if (RST) begin
      r_frame <= '0;
      r_idx <= '0;
      r_csum <= '0;
      r_tmo <= '0;
      RS_DATAIN <= '0;
      RS_TRG_WRITE <= 1'b0;
      busy <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      RS_TRG_WRITE <= w_send;
      busy <= w_state_nx != IDLE;
      if (w_pop) begin
        r_frame <= r_mem[r_rp];
        r_idx <= '0;
        r_csum <= '0;
      end
      if (w_send) begin
        RS_DATAIN <= w_byte;
        r_csum <= r_csum ^ w_byte;
        r_frame <= r_frame << 8;
        r_tmo <= '0;
      end
      if (r_state == WAIT_DONE && !w_done && !w_tmo) r_tmo <= r_tmo + 1'b1;
      if (w_done) r_idx <= r_idx + 1'b1;
      if (w_tmo) timeout_err <= 1'b1;
    end
endmodule
